// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the RV64M funct3 ops.
// Performs one shift-add (multiply) or restoring-divide step per cycle on operand magnitudes.
// Divide-by-zero and signed overflow finish in one cycle without iterating.
//
// Ports:
//   clk, async_reset      clock, asynchronous active-low reset
//   start, flush          request a new op (idle only), kill the in-flight op
//   op, a, b, tag_in      funct3, rs1, rs2 and the rd tag of the request
//   busy                  op in flight (stall)
//   done                  one-cycle completion pulse
//   result, tag_out       result and rd tag, held until the next completion
module muldiv_iter #(
    parameter int unsigned bits      = 64,
    parameter int unsigned tag_width = 5
) (
    input  logic                 clk,
    input  logic                 async_reset,
    input  logic                 start,
    input  logic                 flush,
    input  logic [2:0]           op,
    input  logic [bits-1:0]      a,
    input  logic [bits-1:0]      b,
    input  logic [tag_width-1:0] tag_in,
    output logic                 busy,
    output logic                 done,
    output logic [bits-1:0]      result,
    output logic [tag_width-1:0] tag_out
);

    localparam int unsigned CntW = $clog2(bits + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(bits);
    localparam logic [bits-1:0] MinVal = {1'b1, {(bits - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [tag_width-1:0] tag_q, tag_d;
    // hi/lo: product high/low halves, or partial remainder/quotient for divides
    logic [bits-1:0]      hi_q, hi_d;
    logic [bits-1:0]      lo_q, lo_d;
    // multiplicand for multiplies, divisor for divides
    logic [bits-1:0]      opnd_q, opnd_d;
    logic [bits-1:0]      result_q, result_d;
    logic [tag_width-1:0] tag_out_q, tag_out_d;

    // Accept-time decode
    logic            a_signed, b_signed, a_neg, b_neg, res_neg;
    logic [bits-1:0] mag_a, mag_b;
    logic            b_zero, ovf, fast_hit;
    logic [bits-1:0] fast_val;

    always_comb begin
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg    = a_signed & a[bits-1];
        b_neg    = b_signed & b[bits-1];
        mag_a    = a_neg ? -a : a;
        mag_b    = b_neg ? -b : b;
        // Remainder takes the dividend's sign; everything else takes the XOR.
        res_neg  = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
        b_zero   = (b == '0);
        ovf      = ((op == 3'd4) || (op == 3'd6)) && (a == MinVal) && (b == '1);
        fast_hit = op[2] & (b_zero | ovf);
        if (b_zero) begin
            fast_val = op[1] ? a : '1;
        end else begin
            fast_val = op[1] ? '0 : a;
        end
    end

    // One iteration step
    logic [bits:0]   mul_sum;
    logic [bits:0]   rem_sh;
    logic            rem_ge;
    logic [bits-1:0] rem_sub;
    logic [bits-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {hi_q, lo_q[bits-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd_q});
        // Only used when rem_ge, where the true difference fits in bits.
        rem_sub = rem_sh[bits-1:0] - opnd_q;
        if (op_q[2]) begin
            step_hi = rem_ge ? rem_sub : rem_sh[bits-1:0];
            step_lo = {lo_q[bits-2:0], rem_ge};
        end else begin
            step_hi = mul_sum[bits:1];
            step_lo = {mul_sum[0], lo_q[bits-1:1]};
        end
    end

    // Final sign fix and half select
    logic [2*bits-1:0] prod, prod_fix;
    logic [bits-1:0]   div_val, div_fix, fin_val;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        div_val  = op_q[1] ? hi_q : lo_q;
        div_fix  = neg_q ? -div_val : div_val;
        if (op_q[2]) begin
            fin_val = div_fix;
        end else if (op_q == 3'd0) begin
            fin_val = prod_fix[bits-1:0];
        end else begin
            fin_val = prod_fix[2*bits-1:bits];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        tag_d     = tag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    op_d  = op;
                    tag_d = tag_in;
                    neg_d = res_neg;
                    if (fast_hit) begin
                        result_d  = fast_val;
                        tag_out_d = tag_in;
                        state_d   = StDone;
                    end else begin
                        cnt_d   = CntInit;
                        hi_d    = '0;
                        lo_d    = op[2] ? mag_a : mag_b;
                        opnd_d  = op[2] ? mag_b : mag_a;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d  = fin_val;
                    tag_out_d = tag_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            tag_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            tag_q     <= tag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign busy    = (state_q != StIdle);
    // A flush in the done cycle suppresses the pulse.
    assign done    = (state_q == StDone) && !flush;
    assign result  = result_q;
    assign tag_out = tag_out_q;

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

    logic        clk;
    logic        async_reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  tag_in;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  tag_out;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
    localparam logic [2:0] OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;
    localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;
    localparam logic [63:0] NegSeven = 64'hFFFF_FFFF_FFFF_FFF9;

    muldiv_iter #(.bits(64), .tag_width(5)) dut (
        .clk        (clk),
        .async_reset(async_reset),
        .start      (start),
        .flush      (flush),
        .op         (op),
        .a          (a),
        .b          (b),
        .tag_in     (tag_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .tag_out    (tag_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one op for one edge; operands are cleared right after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] t);
        @(negedge clk);
        op = o; a = x; b = y; tag_in = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; tag_in = '0;
    endtask

    // Negedges waited from the first negedge after accept until done; -1 on timeout.
    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) k = -1;
    endtask

    task automatic test_reset;
        async_reset = 1'b1;
        #1 async_reset = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
        n_vec++; if (result !== 64'd0) begin n_err++; $display("FAIL rst_result: got %h want 0", result); end
        n_vec++; if (tag_out !== 5'd0) begin n_err++; $display("FAIL rst_tag: got %h want 0", tag_out); end
        @(negedge clk);
        @(negedge clk);
        async_reset = 1'b1;
    endtask

    task automatic test_mul;
        int k;
        issue(OpMul, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd12);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_rise: got %b want 1", busy); end
        n_vec++; if (result !== 64'd0) begin n_err++; $display("FAIL mul_result_held: got %h want 0", result); end
        wait_done(k);
        n_vec++; if (k !== 65) begin n_err++; $display("FAIL mul_latency: got %0d want 65", k); end
        n_vec++; if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_err++; $display("FAIL mul_result: got %h want ffffffffffffffeb", result); end
        n_vec++; if (tag_out !== 5'd12) begin n_err++; $display("FAIL mul_tag: got %0d want 12", tag_out); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mul_pulse_end: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_mulh;
        int k;
        issue(OpMulhu, AllOnes, 64'd2, 5'd1);
        wait_done(k);
        n_vec++; if (result !== 64'd1) begin n_err++; $display("FAIL mulhu: got %h want 1 (k=%0d)", result, k); end
        issue(OpMulh, AllOnes, 64'd2, 5'd2);
        wait_done(k);
        n_vec++; if (result !== AllOnes) begin n_err++; $display("FAIL mulh: got %h want all ones (k=%0d)", result, k); end
        issue(OpMulhsu, AllOnes, AllOnes, 5'd3);
        wait_done(k);
        n_vec++; if (result !== AllOnes) begin n_err++; $display("FAIL mulhsu: got %h want all ones (k=%0d)", result, k); end
        issue(OpMulhu, AllOnes, AllOnes, 5'd4);
        wait_done(k);
        n_vec++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mulhu_max: got %h want fffffffffffffffe", result); end
    endtask

    task automatic test_div;
        int k;
        issue(OpDiv, NegSeven, 64'd2, 5'd5);
        wait_done(k);
        n_vec++; if (k !== 65) begin n_err++; $display("FAIL div_latency: got %0d want 65", k); end
        n_vec++; if (result !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div: got %h want fffffffffffffffd", result); end
        issue(OpRem, NegSeven, 64'd2, 5'd6);
        wait_done(k);
        n_vec++; if (result !== AllOnes) begin n_err++; $display("FAIL rem: got %h want all ones", result); end
        issue(OpDivu, 64'd100, 64'd7, 5'd7);
        wait_done(k);
        n_vec++; if (result !== 64'd14) begin n_err++; $display("FAIL divu: got %0d want 14", result); end
        issue(OpRemu, 64'd100, 64'd7, 5'd8);
        wait_done(k);
        n_vec++; if (result !== 64'd2) begin n_err++; $display("FAIL remu: got %0d want 2", result); end
        n_vec++; if (tag_out !== 5'd8) begin n_err++; $display("FAIL remu_tag: got %0d want 8", tag_out); end
    endtask

    task automatic test_fast;
        int k;
        issue(OpDivu, 64'd5, 64'd0, 5'd9);
        wait_done(k);
        n_vec++; if (k !== 0) begin n_err++; $display("FAIL fast_latency: got %0d want 0", k); end
        n_vec++; if (result !== AllOnes) begin n_err++; $display("FAIL divu_by0: got %h want all ones", result); end
        n_vec++; if (tag_out !== 5'd9) begin n_err++; $display("FAIL fast_tag: got %0d want 9", tag_out); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fast_busy_end: got %b want 0", busy); end
        issue(OpDiv, MinNeg, AllOnes, 5'd10);
        wait_done(k);
        n_vec++; if (k !== 0 || result !== MinNeg) begin n_err++; $display("FAIL div_ovf: got %h k=%0d want 8000000000000000 k=0", result, k); end
        issue(OpRem, MinNeg, AllOnes, 5'd11);
        wait_done(k);
        n_vec++; if (k !== 0 || result !== 64'd0) begin n_err++; $display("FAIL rem_ovf: got %h k=%0d want 0 k=0", result, k); end
        issue(OpRem, NegSeven, 64'd0, 5'd13);
        wait_done(k);
        n_vec++; if (k !== 0 || result !== NegSeven) begin n_err++; $display("FAIL rem_by0: got %h k=%0d want fffffffffffffff9 k=0", result, k); end
    endtask

    task automatic test_flush;
        int seen;
        // Flush on the 10th busy cycle.
        issue(OpDiv, 64'd1000, 64'd3, 5'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL flush_idle: got busy=%b done=%b want 0 0", busy, done); end
        n_vec++; if (result !== NegSeven || tag_out !== 5'd13) begin n_err++; $display("FAIL flush_hold: got %h tag %0d want fffffffffffffff9 tag 13", result, tag_out); end
        seen = 0;
        repeat (80) begin @(negedge clk); if (done === 1'b1) seen++; end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL flush_no_done: got %0d pulses want 0", seen); end
        // Flush coinciding with the finalising edge.
        issue(OpDivu, 64'd100, 64'd7, 5'd14);
        repeat (64) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++; if (done !== 1'b0 || busy !== 1'b0 || result !== NegSeven) begin n_err++; $display("FAIL flush_last: got done=%b busy=%b res=%h want 0 0 fffffffffffffff9", done, busy, result); end
        // Flush beats start in idle.
        @(negedge clk);
        op = OpDivu; a = 64'd9; b = 64'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_prio: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int k;
        issue(OpDivu, 64'd100, 64'd7, 5'd9);
        repeat (3) @(negedge clk);
        op = OpMul; a = 64'd3; b = 64'd5; tag_in = 5'd1; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(k);
        n_vec++; if (result !== 64'd14 || tag_out !== 5'd9) begin n_err++; $display("FAIL busy_start_ignored: got %0d tag %0d want 14 tag 9", result, tag_out); end
        // Start in the done cycle is dropped.
        op = OpMul; a = 64'd3; b = 64'd5; tag_in = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (busy !== 1'b0 || result !== 64'd14) begin n_err++; $display("FAIL done_start_ignored: got busy=%b res=%0d want 0 14", busy, result); end
        issue(OpMul, 64'd3, 64'd5, 5'd2);
        wait_done(k);
        n_vec++; if (k !== 65 || result !== 64'd15 || tag_out !== 5'd2) begin n_err++; $display("FAIL retry_mul: got k=%0d res=%0d tag=%0d want 65 15 2", k, result, tag_out); end
    endtask

    task automatic test_reset_mid_op;
        int seen;
        issue(OpMul, 64'd6, 64'd7, 5'd4);
        repeat (5) @(negedge clk);
        #2 async_reset = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", busy, done); end
        n_vec++; if (result !== 64'd0 || tag_out !== 5'd0) begin n_err++; $display("FAIL midrst_data: got %h tag %0d want 0 tag 0", result, tag_out); end
        @(negedge clk);
        async_reset = 1'b1;
        seen = 0;
        repeat (80) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst_quiet: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; tag_in = '0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast();
        test_flush();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV64M multiply/divide execution unit, parametrised in operand width.
- Sits beside the ALU in the EX stage. The hazard logic stalls the pipeline while busy=1; the result enters EX/MEM with its rd tag when done pulses.
- Implements all eight M-extension funct3 ops: one multiply or divide step per cycle, with a fast path for divide special cases.

Parameters:
bits, 64, operand/result width (≥8, even)
tag_width, 5, destination-register tag width carried through with the op

Ports:
clk  in  1  rising-edge clock
async_reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request a new op; accepted only when idle
flush  in  1  abort the in-flight op (branch/jump kill)
op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  in  bits  rs1 operand
b  in  bits  rs2 operand
tag_in  in  tag_width  rd of the requesting instruction
busy  out  1  op in flight; pipeline must stall
done  out  1  one-cycle pulse; result and tag_out valid
result  out  bits  op result; held until the next accept
tag_out  out  tag_width  rd captured at accept

Behaviour:
- Reset (async_reset=0, any time, including mid-op): state=IDLE; busy, done, result, tag_out all 0; counter and internal regs 0.
- States:
  - IDLE: start=1 & flush=0 at an edge → accept. Latch op, tag_in, and operand magnitudes; record result sign. Go to BUSY (counter=bits), or to DONE if a fast-path case applies.
  - BUSY: one step per cycle, counter decrements. At the edge where counter reaches 0, finalise the result (sign fix / high-low select) and go to DONE.
  - DONE: done=1 for exactly this cycle; the next edge returns to IDLE. A start in DONE is not accepted; it must be retried in IDLE.
- busy=1 in BUSY and DONE; busy=0 in IDLE. busy is registered and rises the cycle after accept.
- Latency, normal path: done is high in the cycle following bits+1 edges after the accept edge (bits+2 cycles of busy).
- Latency, fast path: done is high in the cycle after the accept edge.
- Multiply:
  - Shift-add over bits iterations on magnitudes into a 2*bits product.
  - MUL returns the low bits. MULH, MULHSU and MULHU return the high bits.
  - Signedness: MULH treats both operands as signed, MULHSU treats a signed and b unsigned, MULHU treats both as unsigned.
  - A negative product is two's-complemented over the full 2*bits width before selecting the high or low half.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Both apply to signed ops only.
- Fast path (no iteration):
  - b=0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow, a = most-negative and b = -1: DIV → a; REM → 0.
- result and tag_out update only on the edge entering DONE; they are stable at all other times.
- start while busy=1 is ignored. Operands need not be held after the accept edge.
- flush=1 in BUSY or DONE → IDLE at the next edge. done is forced to 0 that cycle, and result and tag_out keep their previous values.
- flush has priority over start in IDLE.
- A simultaneous flush and counter=0 counts as a flush: no done.

Test Plan:
- Reset mid-op: accept MUL, then pull async_reset low between edges → busy, done, result immediately 0; no done pulse follows release.
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) → done exactly bits+1 edges after accept, result=0xFFFF_FFFF_FFFF_FFEB, tag_out=tag_in (e.g. 5'd12).
- MULHU a=0xFFFF_FFFF_FFFF_FFFF, b=2 → result=1. Same operands with MULH → result=0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-7, b=2 → result=-3 (…FFFD). REM a=-7, b=2 → result=-1. DIVU a=100, b=7 → result=14. REMU a=100, b=7 → result=2.
- DIVU a=5, b=0 → done in the cycle after accept, result=all ones. DIV a=0x8000_0000_0000_0000, b=-1 → result=a. REM with the same operands → 0.
- Flush and start handling:
  - Start DIV, assert flush on the 10th busy cycle → IDLE next edge, no done, result unchanged.
  - Assert start during busy with different operands → ignored; the original op completes with the original result.
